// File: rtl/ascon_fsm.sv
// ascon_fsm: ASCON-128 encryption control FSM (optional abort input via ASCON_FSM_ABORT_EN)
module ascon_fsm #(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
`ifdef ASCON_FSM_ABORT_EN
  input  logic       abort_i,
`endif
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       sel_o,
  output logic [3:0] round_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_out_cipher_o,
  output logic       en_out_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_rnd, w_rnd, r_blk, w_blk;
  logic       r_cv, r_done, w_kill;
  localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
  localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);
`ifdef ASCON_FSM_ABORT_EN
  assign w_kill = reset_i | (abort_i & (r_state != S_IDLE));
`else
  assign w_kill = reset_i;
`endif
  always_comb begin
    data_ready_o       = 1'b0;
    sel_o              = 1'b0;
    round_o            = 4'd0;
    en_reg_state_o     = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_key_begin_o = 1'b0;
    en_xor_key_end_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_out_cipher_o    = 1'b0;
    en_out_tag_o       = 1'b0;
    w_next             = r_state;
    w_rnd              = r_rnd;
    w_blk              = r_blk;
    case (r_state)
      S_IDLE: if (start_i) begin
        en_reg_state_o = 1'b1;
        w_next         = S_INIT;
        w_rnd          = 4'd1;
      end
      S_INIT, S_FINAL: begin
        sel_o          = 1'b1;
        en_reg_state_o = 1'b1;
        round_o        = r_rnd;
        w_rnd          = r_rnd + 4'd1;
        if (r_rnd == 4'd11) begin
          en_xor_key_end_o = 1'b1;
          en_out_tag_o     = r_state == S_FINAL;
          w_next           = r_state == S_FINAL ? S_DONE : S_WAIT_AD;
          w_rnd            = 4'd0;
          w_blk            = 4'd0;
        end
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_xor_data_o  = 1'b1;
          sel_o          = 1'b1;
          en_reg_state_o = 1'b1;
          round_o        = 4'd6;
          w_next         = S_AD;
          w_rnd          = 4'd7;
        end
      end
      S_AD, S_PT: begin
        sel_o          = 1'b1;
        en_reg_state_o = 1'b1;
        round_o        = r_rnd;
        w_rnd          = r_rnd + 4'd1;
        if (r_rnd == 4'd11) begin
          w_rnd = 4'd0;
          w_blk = r_blk + 4'd1;
          if (r_state == S_PT) w_next = S_WAIT_PT;
          else if (r_blk == AD_LAST) begin
            en_xor_lsb_o = 1'b1;
            w_next       = S_WAIT_PT;
            w_blk        = 4'd0;
          end else w_next = S_WAIT_AD;
        end
      end
      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_xor_data_o   = 1'b1;
          en_out_cipher_o = 1'b1;
          sel_o           = 1'b1;
          en_reg_state_o  = 1'b1;
          // last block skips its PT rounds and folds straight into finalisation
          if (r_blk == PT_LAST) begin
            en_xor_key_begin_o = 1'b1;
            w_next             = S_FINAL;
            w_rnd              = 4'd1;
            w_blk              = 4'd0;
          end else begin
            round_o = 4'd6;
            w_next  = S_PT;
            w_rnd   = 4'd7;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        w_rnd  = 4'd0;
        w_blk  = 4'd0;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_kill) begin
      data_ready_o       = 1'b0;
      sel_o              = 1'b0;
      round_o            = 4'd0;
      en_reg_state_o     = 1'b0;
      en_xor_data_o      = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_xor_lsb_o       = 1'b0;
      en_out_cipher_o    = 1'b0;
      en_out_tag_o       = 1'b0;
      w_next             = S_IDLE;
      w_rnd              = 4'd0;
      w_blk              = 4'd0;
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_blk   <= 4'd0;
      r_cv    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rnd   <= w_rnd;
      r_blk   <= w_blk;
      r_cv    <= en_out_cipher_o;
      r_done  <= w_next == S_DONE;
    end
  end
  assign cipher_valid_o = r_cv;
  assign done_o         = r_done;
  assign busy_o         = r_state != S_IDLE;
endmodule

// File: tb/tb_ascon_fsm.sv
// tb_ascon_fsm: table-driven timing checks plus cipher/done scoreboard for ascon_fsm
module tb_ascon_fsm;
  logic clock_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, data_valid_i = 1'b0;
  logic abort_i = 1'b0;
  logic rdy1, sel1, reg1, xd1, xkb1, xke1, lsb1, oc1, ot1, cv1, busy1, done1;
  logic rdy2, sel2, reg2, xd2, xkb2, xke2, lsb2, oc2, ot2, cv2, busy2, done2;
  logic [3:0] rnd1, rnd2;
  logic [15:0] o1, o2;
  logic [15:0] log1 [0:99];
  logic [15:0] log2 [0:99];
  int errors = 0, checks = 0;
  int q_cv[$], q_done[$];
  always #5 clock_i = ~clock_i;
  ascon_fsm u1 (
    .clock_i(clock_i), .reset_i(reset_i),
`ifdef ASCON_FSM_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .data_valid_i(data_valid_i), .data_ready_o(rdy1), .sel_o(sel1),
    .round_o(rnd1), .en_reg_state_o(reg1), .en_xor_data_o(xd1), .en_xor_key_begin_o(xkb1),
    .en_xor_key_end_o(xke1), .en_xor_lsb_o(lsb1), .en_out_cipher_o(oc1), .en_out_tag_o(ot1),
    .cipher_valid_o(cv1), .busy_o(busy1), .done_o(done1));
  ascon_fsm #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) u2 (
    .clock_i(clock_i), .reset_i(reset_i),
`ifdef ASCON_FSM_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .data_valid_i(data_valid_i), .data_ready_o(rdy2), .sel_o(sel2),
    .round_o(rnd2), .en_reg_state_o(reg2), .en_xor_data_o(xd2), .en_xor_key_begin_o(xkb2),
    .en_xor_key_end_o(xke2), .en_xor_lsb_o(lsb2), .en_out_cipher_o(oc2), .en_out_tag_o(ot2),
    .cipher_valid_o(cv2), .busy_o(busy2), .done_o(done2));
  assign o1 = {rdy1, sel1, rnd1, reg1, xd1, xkb1, xke1, lsb1, oc1, ot1, cv1, busy1, done1};
  assign o2 = {rdy2, sel2, rnd2, reg2, xd2, xkb2, xke2, lsb2, oc2, ot2, cv2, busy2, done2};
  typedef struct {int scn; int dut; int cyc; logic [15:0] exp; string name;} vec_t;
  vec_t tbl[$];
  function automatic logic [15:0] mk(bit rdy, bit sel, logic [3:0] rnd, bit rg, bit xd, bit xkb,
                                     bit xke, bit lsb, bit oc, bit ot, bit cv, bit busy, bit done);
    return {rdy, sel, rnd, rg, xd, xkb, xke, lsb, oc, ot, cv, busy, done};
  endfunction
  task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask
  task automatic run(input bit stall, input int rst_cyc, input bit extra_start, input int ncyc);
    int e;
    for (int c = 0; c < ncyc; c++) begin
      start_i      = (c == 0) || (extra_start && c == 5);
      data_valid_i = !(stall && c >= 30 && c < 35);
      reset_i      = (c == rst_cyc);
      if (c == 0) begin
        q_cv.push_back(19);
        if (rst_cyc < 0) begin
          q_cv.push_back(25);
          q_cv.push_back(stall ? 36 : 31);
          q_cv.push_back(stall ? 42 : 37);
          q_done.push_back(stall ? 53 : 48);
        end
      end
      @(negedge clock_i);
      log1[c] = o1;
      log2[c] = o2;
      if (cv1) begin
        if (q_cv.size() == 0) chk("cv_unexpected", c, 16'(c), 16'hffff);
        else begin e = q_cv.pop_front(); chk("cv_cycle", c, 16'(c), 16'(e)); end
      end
      if (done1) begin
        if (q_done.size() == 0) chk("done_unexpected", c, 16'(c), 16'hffff);
        else begin e = q_done.pop_front(); chk("done_cycle", c, 16'(c), 16'(e)); end
      end
      @(posedge clock_i);
      #1;
    end
    start_i = 1'b0;
    data_valid_i = 1'b0;
    reset_i = 1'b0;
    chk("sb_drained", ncyc, 16'(q_cv.size() + q_done.size()), 16'd0);
    q_cv.delete();
    q_done.delete();
  endtask
  task automatic check_scn(input int scn);
    foreach (tbl[i])
      if (tbl[i].scn == scn)
        chk(tbl[i].name, tbl[i].cyc, tbl[i].dut == 1 ? log1[tbl[i].cyc] : log2[tbl[i].cyc], tbl[i].exp);
    if (scn == 1) begin
      for (int c = 0; c < 12; c++) chk("round_init", c, 16'(log1[c][13:10]), 16'(c));
      for (int c = 37; c < 48; c++) chk("round_final", c, 16'(log1[c][13:10]), 16'(c - 36));
      for (int c = 12; c < 18; c++) chk("round_ad", c, 16'(log1[c][13:10]), 16'(c - 6));
    end
  endtask
  initial begin
    tbl.push_back('{1, 1, 0,  mk(0,0,0,1,0,0,0,0,0,0,0,0,0), "idle_start"});
    tbl.push_back('{1, 1, 5,  mk(0,1,5,1,0,0,0,0,0,0,0,1,0), "init_r5"});
    tbl.push_back('{1, 1, 11, mk(0,1,11,1,0,0,1,0,0,0,0,1,0), "init_keyend"});
    tbl.push_back('{1, 1, 12, mk(1,1,6,1,1,0,0,0,0,0,0,1,0), "ad_accept"});
    tbl.push_back('{1, 1, 17, mk(0,1,11,1,0,0,0,1,0,0,0,1,0), "ad_lsb"});
    tbl.push_back('{1, 1, 18, mk(1,1,6,1,1,0,0,0,1,0,0,1,0), "pt0_accept"});
    tbl.push_back('{1, 1, 19, mk(0,1,7,1,0,0,0,0,0,0,1,1,0), "pt0_r7"});
    tbl.push_back('{1, 1, 36, mk(1,1,0,1,1,1,0,0,1,0,0,1,0), "pt_last"});
    tbl.push_back('{1, 1, 37, mk(0,1,1,1,0,0,0,0,0,0,1,1,0), "final_r1"});
    tbl.push_back('{1, 1, 47, mk(0,1,11,1,0,0,1,0,0,1,0,1,0), "final_tag"});
    tbl.push_back('{1, 1, 48, mk(0,0,0,0,0,0,0,0,0,0,0,1,1), "done"});
    tbl.push_back('{1, 1, 49, mk(0,0,0,0,0,0,0,0,0,0,0,0,0), "idle_after"});
    tbl.push_back('{1, 2, 17, mk(0,1,11,1,0,0,0,0,0,0,0,1,0), "ad2_blk0_end"});
    tbl.push_back('{1, 2, 18, mk(1,1,6,1,1,0,0,0,0,0,0,1,0), "ad2_blk1_accept"});
    tbl.push_back('{1, 2, 23, mk(0,1,11,1,0,0,0,1,0,0,0,1,0), "ad2_lsb"});
    tbl.push_back('{1, 2, 24, mk(1,1,0,1,1,1,0,0,1,0,0,1,0), "pt1_last"});
    tbl.push_back('{1, 2, 25, mk(0,1,1,1,0,0,0,0,0,0,1,1,0), "pt1_final_r1"});
    tbl.push_back('{1, 2, 35, mk(0,1,11,1,0,0,1,0,0,1,0,1,0), "pt1_tag"});
    tbl.push_back('{1, 2, 36, mk(0,0,0,0,0,0,0,0,0,0,0,1,1), "pt1_done"});
    tbl.push_back('{2, 1, 30, mk(1,0,0,0,0,0,0,0,0,0,0,1,0), "stall_first"});
    tbl.push_back('{2, 1, 34, mk(1,0,0,0,0,0,0,0,0,0,0,1,0), "stall_last"});
    tbl.push_back('{2, 1, 35, mk(1,1,6,1,1,0,0,0,1,0,0,1,0), "stall_accept"});
    tbl.push_back('{2, 1, 53, mk(0,0,0,0,0,0,0,0,0,0,0,1,1), "stall_done"});
    tbl.push_back('{3, 1, 20, mk(0,0,0,0,0,0,0,0,0,0,0,1,0), "reset_cycle"});
    tbl.push_back('{3, 1, 21, mk(0,0,0,0,0,0,0,0,0,0,0,0,0), "reset_idle"});
    tbl.push_back('{3, 1, 22, mk(0,0,0,0,0,0,0,0,0,0,0,0,0), "reset_stays"});
    repeat (3) @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("reset_state", 0, o1, 16'h0000);
    @(posedge clock_i);
    #1;
    run(1'b0, -1, 1'b0, 60); check_scn(1);
    run(1'b1, -1, 1'b0, 60); check_scn(2);
    run(1'b0, 20, 1'b0, 40); check_scn(3);
    run(1'b0, -1, 1'b0, 60); check_scn(1);
    run(1'b0, -1, 1'b1, 60); check_scn(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ascon_fsm.md
Name: ascon_fsm

Overview:
- Control FSM for the ASCON-128 encryption datapath.
- Sits directly upstream of the round/permutation block and drives all of its control inputs: state mux select, round index, state-register enable, begin/end XOR enables, and cipher/tag capture enables.
- Sequences four phases: initialisation (12 rounds), associated data (6 rounds per block), plaintext (6 rounds per block), finalisation (12 rounds).
- Accepts one 64-bit block per valid/ready handshake and reports cipher-valid and done.

Parameters:
- NB_AD_BLOCKS, 1, number of associated-data blocks per message; legal range 1..15.
- NB_PT_BLOCKS, 4, number of plaintext blocks per message; legal range 1..15.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  start-of-message pulse; sampled in IDLE only.
- data_valid_i  in  1  upstream 64-bit block is present on the datapath data input.
- data_ready_o  out  1  FSM can accept a block this cycle.
- sel_o  out  1  0 = load external initial state (IV||K||N); 1 = feed back the state register.
- round_o  out  4  round-constant index, 0..11.
- en_reg_state_o  out  1  state register enable.
- en_xor_data_o  out  1  XOR data block into x0 before the round.
- en_xor_key_begin_o  out  1  XOR key into x1,x2 before the round.
- en_xor_key_end_o  out  1  XOR key into x3,x4 after the round.
- en_xor_lsb_o  out  1  XOR domain-separation bit into x4 LSB after the round.
- en_out_cipher_o  out  1  capture x0 as cipher word.
- en_out_tag_o  out  1  capture x3,x4 as tag.
- cipher_valid_o  out  1  registered; cipher output register holds a new word.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  registered one-cycle pulse; tag register is valid.

Behaviour:
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- Internal counters: 4-bit round counter rnd; 4-bit block counter blk.
- Control outputs (sel_o through en_out_tag_o, and data_ready_o) are combinational from state, rnd, blk and data_valid_i. They are all 0 in IDLE, WAIT_* without valid, DONE, and while reset_i is high.
- cipher_valid_o and done_o are flops, reset to 0.
- Reset is synchronous and overrides everything, including mid-message: next state IDLE, rnd = 0, blk = 0, registered outputs 0.
- IDLE:
  - start_i = 1 gives sel_o = 0, round_o = 0, en_reg_state_o = 1; next state INIT with rnd = 1.
  - start_i while not in IDLE is ignored.
- INIT (rnd 1..11):
  - sel_o = 1, en_reg_state_o = 1, round_o = rnd.
  - At rnd = 11: en_xor_key_end_o = 1; next state WAIT_AD with blk = 0.
- WAIT_AD:
  - data_ready_o = 1.
  - On data_valid_i: en_xor_data_o = 1, sel_o = 1, en_reg_state_o = 1, round_o = 6; next state AD with rnd = 7.
- AD (rnd 7..11):
  - Same enables as INIT, without XORs.
  - At rnd = 11: blk increments. If blk was NB_AD_BLOCKS-1: en_xor_lsb_o = 1, next state WAIT_PT, blk = 0. Otherwise next state WAIT_AD.
- WAIT_PT:
  - data_ready_o = 1.
  - On data_valid_i: en_xor_data_o = 1, en_out_cipher_o = 1, sel_o = 1, en_reg_state_o = 1.
  - Block not last: round_o = 6, next state PT with rnd = 7.
  - Last block (blk = NB_PT_BLOCKS-1): additionally en_xor_key_begin_o = 1, round_o = 0, next state FINAL with rnd = 1.
- PT (rnd 7..11): at rnd = 11, blk increments; next state WAIT_PT.
- FINAL (rnd 1..11): at rnd = 11, en_xor_key_end_o = 1 and en_out_tag_o = 1; next state DONE.
- DONE: done_o = 1 for this single cycle; next state IDLE. busy_o is 0 only in IDLE.
- cipher_valid_o = en_out_cipher_o delayed one cycle.
- data_valid_i outside WAIT_* states is ignored; no block is consumed.
- Handshake: a block is consumed exactly on cycles where data_ready_o and data_valid_i are both 1. No backpressure exists inside a round phase.
- Latency with valid held high: start cycle 0 → done_o at cycle 12 + 6·NB_AD_BLOCKS + 6·(NB_PT_BLOCKS-1) + 12.
- Counter widths: blk compares against NB_*-1 and never wraps within a message; counters clear on entry to IDLE.

Optional Feature:
- Macro: ASCON_FSM_ABORT_EN.
- When defined:
  - Adds input abort_i (1 bit).
  - abort_i = 1 in any non-IDLE state: all combinational control outputs are forced to 0 that cycle, next state IDLE, counters clear, no done_o pulse.
  - abort_i has lower priority than reset_i and is ignored in IDLE.
- When not defined: no port and no abort path.

Test Plan:
- Defaults, data_valid_i held 1, start_i at cycle 0 → en_xor_key_end_o at cycle 11; AD accept at cycle 12; en_xor_lsb_o at cycle 17; cipher_valid_o at cycles 19, 25, 31, 37; en_out_tag_o at cycle 47; done_o at cycle 48; busy_o low at cycle 49.
- Round sequencing → round_o reads 0..11 in INIT, 6..11 per AD/PT block, and 0 at cycle 36 (last PT accept with en_xor_key_begin_o = 1), then 1..11.
- data_valid_i low for 5 cycles in WAIT_PT before block 2 → data_ready_o = 1 and all enables 0 during the stall; done_o delayed by exactly 5 cycles (cycle 53).
- reset_i asserted at cycle 20 (mid-PT) → cycle 21 in IDLE with all outputs 0; a fresh start_i reproduces the scenario-1 timing.
- start_i pulsed at cycle 5 and data_valid_i during INIT → no effect; timing identical to scenario 1.
- NB_AD_BLOCKS = 2, NB_PT_BLOCKS = 1 → en_xor_lsb_o only at cycle 23; PT accept and finalisation begin at cycle 24; done_o at cycle 36.
